// File: rtl/mrna_iso_pkg.sv
// Shared types and constants for the mRNA isolation valve sequencer:
// state encodings, valve vector bit positions and default phase durations.
package mrna_iso_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_LOAD_CELLS = 4'd1,
      ST_LOAD_BEADS = 4'd2,
      ST_LYSIS      = 4'd3,
      ST_MIX        = 4'd4,
      ST_SEPARATE   = 4'd5,
      ST_WASH       = 4'd6,
      ST_COLLECT    = 4'd7,
      ST_DONE       = 4'd8
   } state_e;

   localparam int NUM_VALVES  = 13;
   localparam int V_COLLECT   = 0;
   localparam int V_LYSIS_IN  = 1;
   localparam int V_LYSIS_OUT = 2;
   localparam int V_PUSH      = 3;
   localparam int V_PUMP1     = 4;
   localparam int V_PUMP2     = 5;
   localparam int V_PUMP3     = 6;
   localparam int V_SEP       = 7;
   localparam int V_SIEVE     = 8;
   localparam int V_WASTE     = 9;
   localparam int V_BEADS     = 10;
   localparam int V_CELLS_IN  = 11;
   localparam int V_CELLS_OUT = 12;

   localparam logic VALVE_CLOSED = 1'b1;
   localparam logic VALVE_OPEN   = ~VALVE_CLOSED;

   localparam int DEF_T_LOAD     = 8;
   localparam int DEF_T_LYSIS    = 16;
   localparam int DEF_MIX_CYCLES = 4;
   localparam int DEF_PUMP_DIV   = 2;
   localparam int DEF_T_SEP      = 8;
   localparam int DEF_T_WASH     = 8;
   localparam int DEF_T_COLLECT  = 8;
   localparam int DEF_CNT_W      = 16;

   function automatic state_e succ_state(input state_e st);
      case (st)
         ST_LOAD_CELLS: return ST_LOAD_BEADS;
         ST_LOAD_BEADS: return ST_LYSIS;
         ST_LYSIS:      return ST_MIX;
         ST_MIX:        return ST_SEPARATE;
         ST_SEPARATE:   return ST_WASH;
         ST_WASH:       return ST_COLLECT;
         ST_COLLECT:    return ST_DONE;
         default:       return ST_IDLE;
      endcase
   endfunction

   // pumps is {pump1, pump2, pump3}; only honoured in MIX
   function automatic logic [NUM_VALVES-1:0] valve_pattern(input state_e st,
                                                           input logic [2:0] pumps);
      logic [NUM_VALVES-1:0] v;
      v = {NUM_VALVES{VALVE_CLOSED}};
      case (st)
         ST_LOAD_CELLS: begin
            v[V_CELLS_IN]  = VALVE_OPEN;
            v[V_CELLS_OUT] = VALVE_OPEN;
         end
         ST_LOAD_BEADS: begin
            v[V_BEADS]     = VALVE_OPEN;
            v[V_CELLS_OUT] = VALVE_OPEN;
         end
         ST_LYSIS: begin
            v[V_LYSIS_IN]  = VALVE_OPEN;
            v[V_LYSIS_OUT] = VALVE_OPEN;
         end
         ST_MIX: begin
            v[V_PUMP1] = pumps[2];
            v[V_PUMP2] = pumps[1];
            v[V_PUMP3] = pumps[0];
         end
         ST_SEPARATE: begin
            v[V_SEP]   = VALVE_OPEN;
            v[V_SIEVE] = VALVE_OPEN;
            v[V_WASTE] = VALVE_OPEN;
         end
         ST_WASH: begin
            v[V_PUSH]  = VALVE_OPEN;
            v[V_WASTE] = VALVE_OPEN;
         end
         ST_COLLECT: begin
            v[V_PUSH]    = VALVE_OPEN;
            v[V_COLLECT] = VALVE_OPEN;
         end
         default: ;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/mrna_iso_pump_phaser.sv
// Three-phase peristaltic pattern generator. pump_pat is the pattern for the
// NEXT clock so the parent can register it alongside its next-state decode.
module mrna_iso_pump_phaser #(
   parameter int PUMP_DIV   = 2,
   parameter int MIX_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       clear,
   output logic [2:0] pump_pat,
   output logic       cycle_done
);

   localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
   localparam int CYC_W = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MIX_CYCLES - 1);

   logic [DIV_W-1:0] div_q, div_n;
   logic [1:0]       step_q, step_n;
   logic [CYC_W-1:0] cyc_q, cyc_n;
   logic             last_div, last_step, last_cyc;

   always_comb begin
      div_n      = div_q;
      step_n     = step_q;
      cyc_n      = cyc_q;
      last_div   = (div_q == DIV_LAST);
      last_step  = (step_q == 2'd2);
      last_cyc   = (cyc_q == CYC_LAST);
      cycle_done = enable && last_div && last_step && last_cyc;
      if (clear) begin
         div_n  = '0;
         step_n = '0;
         cyc_n  = '0;
      end else if (enable) begin
         if (last_div) begin
            div_n = '0;
            if (last_step) begin
               step_n = '0;
               cyc_n  = last_cyc ? '0 : cyc_q + CYC_W'(1);
            end else begin
               step_n = step_q + 2'd1;
            end
         end else begin
            div_n = div_q + DIV_W'(1);
         end
      end
      case (step_n)
         2'd0:    pump_pat = 3'b011;
         2'd1:    pump_pat = 3'b101;
         default: pump_pat = 3'b110;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         step_q <= '0;
         cyc_q  <= '0;
      end else begin
         div_q  <= div_n;
         step_q <= step_n;
         cyc_q  <= cyc_n;
      end
   end

endmodule

// File: rtl/mrna_iso_valve_seq.sv
// Isolation-run sequencer driving the 13 control-layer valves of the mRNA bank.
// Optional MRNA_SEQ_STEP_EN adds step/waiting for host-paced phase advance.
module mrna_iso_valve_seq
   import mrna_iso_pkg::*;
#(
   parameter int T_LOAD     = DEF_T_LOAD,
   parameter int T_LYSIS    = DEF_T_LYSIS,
   parameter int MIX_CYCLES = DEF_MIX_CYCLES,
   parameter int PUMP_DIV   = DEF_PUMP_DIV,
   parameter int T_SEP      = DEF_T_SEP,
   parameter int T_WASH     = DEF_T_WASH,
   parameter int T_COLLECT  = DEF_T_COLLECT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
`ifdef MRNA_SEQ_STEP_EN
   input  logic       step,
   output logic       waiting,
`endif
   output logic       busy,
   output logic       done,
   output logic [3:0] phase,
   output logic       collect_ctrl,
   output logic       lysis_in_ctrl,
   output logic       lysis_out_ctrl,
   output logic       push_ctrl,
   output logic       pump1,
   output logic       pump2,
   output logic       pump3,
   output logic       sep_ctrl,
   output logic       sieve_ctrl,
   output logic       waste_ctrl,
   output logic       beads_ctrl,
   output logic       cells_in_ctrl,
   output logic       cells_out_ctrl
);

   state_e                state_q, nxt;
   logic [CNT_W-1:0]      timer_q, timer_nxt;
   logic [NUM_VALVES-1:0] valve_q;
   logic                  expired;
   logic                  mix_en;
   logic                  mix_done;
   logic [2:0]            pump_pat;
   logic [2:0]            pumps_eff;
`ifdef MRNA_SEQ_STEP_EN
   logic                  hold_q, hold_nxt;
   assign mix_en    = (state_q == ST_MIX) && !hold_q;
   assign pumps_eff = hold_nxt ? 3'b111 : pump_pat;
   assign waiting   = hold_q;
`else
   assign mix_en    = (state_q == ST_MIX);
   assign pumps_eff = pump_pat;
`endif

   mrna_iso_pump_phaser #(
      .PUMP_DIV   (PUMP_DIV),
      .MIX_CYCLES (MIX_CYCLES)
   ) u_phaser (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (mix_en),
      .clear      (state_q != ST_MIX),
      .pump_pat   (pump_pat),
      .cycle_done (mix_done)
   );

   // MIX length is owned by the phaser so the pump pattern always ends on a whole cycle
   always_comb begin
      case (state_q)
         ST_LOAD_CELLS,
         ST_LOAD_BEADS: expired = (timer_q == CNT_W'(T_LOAD - 1));
         ST_LYSIS:      expired = (timer_q == CNT_W'(T_LYSIS - 1));
         ST_MIX:        expired = mix_done;
         ST_SEPARATE:   expired = (timer_q == CNT_W'(T_SEP - 1));
         ST_WASH:       expired = (timer_q == CNT_W'(T_WASH - 1));
         ST_COLLECT:    expired = (timer_q == CNT_W'(T_COLLECT - 1));
         default:       expired = 1'b0;
      endcase
   end

   always_comb begin
      nxt       = state_q;
      timer_nxt = timer_q + CNT_W'(1);
`ifdef MRNA_SEQ_STEP_EN
      hold_nxt  = 1'b0;
`endif
      if (state_q == ST_IDLE) begin
         timer_nxt = '0;
         if (start && !abort) nxt = ST_LOAD_CELLS;
      end else if (abort) begin
         nxt       = ST_IDLE;
         timer_nxt = '0;
      end else if (state_q == ST_DONE) begin
         nxt       = ST_IDLE;
         timer_nxt = '0;
`ifdef MRNA_SEQ_STEP_EN
      end else if (hold_q) begin
         timer_nxt = timer_q;
         if (step) begin
            nxt       = succ_state(state_q);
            timer_nxt = '0;
         end else begin
            hold_nxt = 1'b1;
         end
      end else if (expired) begin
         hold_nxt  = 1'b1;
         timer_nxt = timer_q;
`else
      end else if (expired) begin
         nxt       = succ_state(state_q);
         timer_nxt = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         valve_q <= {NUM_VALVES{VALVE_CLOSED}};
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef MRNA_SEQ_STEP_EN
         hold_q  <= 1'b0;
`endif
      end else begin
         state_q <= nxt;
         timer_q <= timer_nxt;
         valve_q <= valve_pattern(nxt, pumps_eff);
         busy    <= (nxt != ST_IDLE);
         done    <= (nxt == ST_DONE);
`ifdef MRNA_SEQ_STEP_EN
         hold_q  <= hold_nxt;
`endif
      end
   end

   assign phase          = state_q;
   assign collect_ctrl   = valve_q[V_COLLECT];
   assign lysis_in_ctrl  = valve_q[V_LYSIS_IN];
   assign lysis_out_ctrl = valve_q[V_LYSIS_OUT];
   assign push_ctrl      = valve_q[V_PUSH];
   assign pump1          = valve_q[V_PUMP1];
   assign pump2          = valve_q[V_PUMP2];
   assign pump3          = valve_q[V_PUMP3];
   assign sep_ctrl       = valve_q[V_SEP];
   assign sieve_ctrl     = valve_q[V_SIEVE];
   assign waste_ctrl     = valve_q[V_WASTE];
   assign beads_ctrl     = valve_q[V_BEADS];
   assign cells_in_ctrl  = valve_q[V_CELLS_IN];
   assign cells_out_ctrl = valve_q[V_CELLS_OUT];

endmodule

// File: tb/tb_mrna_iso_valve_seq.sv
// Self-checking bench for mrna_iso_valve_seq (default build): a run-trace
// reference model checked every clock under directed and random start/abort.
module tb_mrna_iso_valve_seq;

   localparam int T_LOAD     = 8;
   localparam int T_LYSIS    = 16;
   localparam int MIX_CYCLES = 4;
   localparam int PUMP_DIV   = 2;
   localparam int T_SEP      = 8;
   localparam int T_WASH     = 8;
   localparam int T_COLLECT  = 8;
   localparam int T_MIX      = MIX_CYCLES * 3 * PUMP_DIV;

   // bit positions inside the bench's own observed-valve word
   localparam int B_COLLECT = 12, B_LYS_IN = 11, B_LYS_OUT = 10, B_PUSH = 9;
   localparam int B_PUMP1 = 8, B_PUMP2 = 7, B_PUMP3 = 6, B_SEP = 5, B_SIEVE = 4;
   localparam int B_WASTE = 3, B_BEADS = 2, B_CELLS_IN = 1, B_CELLS_OUT = 0;

   logic clk = 1'b0;
   logic rst_n, start, abort;
   logic busy, done;
   logic [3:0] phase;
   logic collect_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl;
   logic pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl;
   logic beads_ctrl, cells_in_ctrl, cells_out_ctrl;
   logic [12:0] obs_v;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  ph;
      logic [12:0] v;
      logic        dn;
   } ent_t;

   ent_t trace_q[$];
   bit   in_run;
   ent_t exp_e;

   always #5 clk = ~clk;

   mrna_iso_valve_seq #(
      .T_LOAD(T_LOAD), .T_LYSIS(T_LYSIS), .MIX_CYCLES(MIX_CYCLES),
      .PUMP_DIV(PUMP_DIV), .T_SEP(T_SEP), .T_WASH(T_WASH),
      .T_COLLECT(T_COLLECT), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .done(done), .phase(phase),
      .collect_ctrl(collect_ctrl), .lysis_in_ctrl(lysis_in_ctrl),
      .lysis_out_ctrl(lysis_out_ctrl), .push_ctrl(push_ctrl),
      .pump1(pump1), .pump2(pump2), .pump3(pump3),
      .sep_ctrl(sep_ctrl), .sieve_ctrl(sieve_ctrl), .waste_ctrl(waste_ctrl),
      .beads_ctrl(beads_ctrl), .cells_in_ctrl(cells_in_ctrl),
      .cells_out_ctrl(cells_out_ctrl)
   );

   assign obs_v = {collect_ctrl, lysis_in_ctrl, lysis_out_ctrl, push_ctrl,
                   pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl,
                   beads_ctrl, cells_in_ctrl, cells_out_ctrl};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // open valves for clock k (0-based) of run phase ph; returned word is 1 = open
   function automatic logic [12:0] open_mask(input int ph, input int k);
      logic [12:0] m;
      m = '0;
      case (ph)
         1: begin m[B_CELLS_IN] = 1'b1; m[B_CELLS_OUT] = 1'b1; end
         2: begin m[B_BEADS] = 1'b1; m[B_CELLS_OUT] = 1'b1; end
         3: begin m[B_LYS_IN] = 1'b1; m[B_LYS_OUT] = 1'b1; end
         4: case ((k / PUMP_DIV) % 3)
               0: m[B_PUMP1] = 1'b1;
               1: m[B_PUMP2] = 1'b1;
               default: m[B_PUMP3] = 1'b1;
            endcase
         5: begin m[B_SEP] = 1'b1; m[B_SIEVE] = 1'b1; m[B_WASTE] = 1'b1; end
         6: begin m[B_PUSH] = 1'b1; m[B_WASTE] = 1'b1; end
         7: begin m[B_PUSH] = 1'b1; m[B_COLLECT] = 1'b1; end
         default: ;
      endcase
      return m;
   endfunction

   function automatic ent_t idle_ent();
      ent_t e;
      e.ph = 4'd0; e.v = '1; e.dn = 1'b0;
      return e;
   endfunction

   task automatic build_run();
      int dur[7];
      ent_t e;
      dur = '{T_LOAD, T_LOAD, T_LYSIS, T_MIX, T_SEP, T_WASH, T_COLLECT};
      trace_q.delete();
      for (int s = 0; s < 7; s++) begin
         for (int k = 0; k < dur[s]; k++) begin
            e.ph = 4'(s + 1);
            e.v  = ~open_mask(s + 1, k);
            e.dn = 1'b0;
            trace_q.push_back(e);
         end
      end
      e.ph = 4'd8; e.v = '1; e.dn = 1'b1;
      trace_q.push_back(e);
   endtask

   task automatic model_reset();
      trace_q.delete();
      in_run = 1'b0;
      exp_e  = idle_ent();
   endtask

   // advance the model by one clock using the inputs held at this edge
   task automatic model_edge();
      if (in_run) begin
         if (abort || trace_q.size() == 0) begin
            trace_q.delete();
            in_run = 1'b0;
            exp_e  = idle_ent();
         end else begin
            exp_e = trace_q.pop_front();
         end
      end else if (start && !abort) begin
         build_run();
         in_run = 1'b1;
         exp_e  = trace_q.pop_front();
      end else begin
         exp_e = idle_ent();
      end
   endtask

   task automatic check_all(input string pfx);
      check_val({pfx, "_phase"},  32'(phase), 32'(exp_e.ph));
      check_val({pfx, "_valves"}, 32'(obs_v), 32'(exp_e.v));
      check_val({pfx, "_busy"},   32'(busy),  32'(exp_e.ph != 4'd0));
      check_val({pfx, "_done"},   32'(done),  32'(exp_e.dn));
   endtask

   task automatic tick(input string pfx);
      @(posedge clk);
      model_edge();
      #1;
      check_all(pfx);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // full run: done must appear 80 clocks after the start edge
      tick("idle");
      start = 1'b1;
      tick("run");
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 200) begin
         tick("run");
         cnt++;
      end
      check_val("run_len", 32'(cnt), 32'd80);
      repeat (3) tick("post");

      // abort during LYSIS at edge 20 after start, then a clean run
      start = 1'b1;
      tick("ab");
      start = 1'b0;
      repeat (19) tick("ab");
      check_val("ab_in_lysis", 32'(phase), 32'd3);
      abort = 1'b1;
      tick("ab_hit");
      abort = 1'b0;
      start = 1'b1;
      tick("ab_restart");
      start = 1'b0;
      repeat (85) tick("ab_rerun");

      // start together with abort in IDLE stays idle
      start = 1'b1;
      abort = 1'b1;
      repeat (3) tick("sa");
      abort = 1'b0;

      // start held through two runs: restart only after DONE->IDLE
      repeat (170) tick("hold");
      start = 1'b0;
      repeat (90) tick("hold_end");

      // asynchronous reset mid-MIX
      start = 1'b1;
      tick("ar");
      start = 1'b0;
      repeat (40) tick("ar");
      check_val("ar_in_mix", 32'(phase), 32'd4);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("ar_async");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick("ar_after");

      // random start/abort traffic
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 99) == 0);
         tick("rnd");
      end
      start = 1'b0;
      abort = 1'b0;
      repeat (90) tick("drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
